bootram_bus_bridge: RTL and testbench
=====================================

Name: bootram_bus_bridge

Overview:
Bus-side initiator for the 2Kx8 single-port boot RAM. It converts 32-bit CPU-native memory requests (valid/ready, addr, wdata, wstrb, rdata) into byte-wide RAM accesses.
- Reads: four sequential byte reads, assembled little-endian.
- Writes: one RAM write per enabled byte lane.
- Placement: between the CPU memory mux and the boot RAM macro port.

Parameters:
ADDR_W, 11, byte-address width of the RAM; ram_ad width.
LANES, 4, byte lanes per bus word. Fixed at 4; other values unsupported.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
valid  in  1  request valid; master holds it stable until ready
ready  out  1  one-cycle completion strobe
addr  in  ADDR_W  byte address; bits [1:0] ignored (word aligned)
wdata  in  32  write data, lane n = wdata[8n+7:8n]
wstrb  in  4  byte enables; 4'b0000 = read
rdata  out  32  read data, valid while ready=1, held until next read completes
ram_ce  out  1  RAM clock enable
ram_oce  out  1  RAM output clock enable (equals ram_ce)
ram_wre  out  1  RAM write enable
ram_reset  out  1  RAM output reset (equals reset)
ram_ad  out  ADDR_W  RAM byte address = {addr[ADDR_W-1:2], lane[1:0]}
ram_din  out  8  RAM write byte
ram_dout  in  8  RAM read byte, valid the cycle after an address is clocked with ram_ce=1 (bypass read mode)

Behaviour:
- Reset state: FSM=IDLE, ready=0, rdata=0, ram_ce=0, ram_wre=0, lane=0, strobe mask=0.
- FSM states: IDLE, READ, DRAIN, WRITE, RESP.
- IDLE:
  - valid=1 and wstrb=0 -> READ, lane=0.
  - valid=1 and wstrb!=0 -> WRITE; load mask=wstrb; lane = lowest set bit of wstrb.
- READ:
  - ram_ce=1, ram_wre=0, ram_ad uses current lane.
  - lane increments each cycle; after lane 3 -> DRAIN.
  - Each cycle after an issue, ram_dout is shifted into rdata byte (lane-1).
- DRAIN: capture byte 3 into rdata[31:24]; -> RESP.
- Read timing: valid sampled at end of cycle 0; issues in cycles 1-4; captures at ends of cycles 2-5; ready=1 in cycle 6.
- WRITE:
  - ram_ce=1, ram_wre=1, ram_din = wdata lane byte.
  - Clear the lane bit in mask; lane = next set bit.
  - Mask empty -> RESP.
  - Lanes with wstrb=0 consume no cycle. wstrb=1111: ready in cycle 5. Single lane: ready in cycle 2.
- RESP: ready=1 for exactly one cycle; ram_ce=0; -> IDLE. Valid during RESP is ignored; the next request is sampled no earlier than the cycle after ready.
- Request hold: addr/wdata/wstrb sampled live and must be held until ready; the bridge does not latch them except the strobe mask.
- rdata update: rdata is modified only during READ/DRAIN. Writes leave it unchanged.
- Reset mid-operation: immediate return to IDLE with reset values; no ready issued. RAM bytes already written stay written.
- Idle outputs: ram_ce=0 and ram_wre=0 in IDLE/RESP; ram_ad/ram_din hold their last value (don't-care).

Optional Feature:
Macro BOOTRAM_BRIDGE_WP_EN adds input port wp (1 bit).
- With macro, wp=1 (sampled in IDLE): write requests go IDLE -> RESP directly. ram_wre stays 0; ready comes in cycle 1.
- Reads are unaffected by wp.
- Without macro: no wp port; writes always performed.

Decomposition:
- Package bootram_bridge_pkg: state enum typedef (IDLE, READ, DRAIN, WRITE, RESP), LANES=4, LANE_W=2, BYTE_W=8.
- Sub-module bootram_lane_next: combinational priority encoder taking a 4-bit mask and returning the lowest set lane plus an empty flag. Used for both the IDLE load and WRITE advance.

Test Plan:
- Read: preload RAM bytes 0..3 = 6F,13,13,13; read addr 0 -> ready in cycle 6; rdata=32'h1313136F; exactly 4 ram_ce cycles with ram_ad 0,1,2,3.
- Full write: addr 0x010, wstrb=1111, wdata=32'hDEADBEEF -> RAM[0x10..0x13]=EF,BE,AD,DE; ready in cycle 5; read back 32'hDEADBEEF.
- Sparse write: addr 0x020, wstrb=0101, wdata=32'h11223344 -> RAM[0x20]=44, RAM[0x22]=22, 0x21/0x23 unchanged; exactly 2 ram_wre cycles; ready in cycle 3.
- Back-to-back: read addr 0x7FC immediately followed by read addr 0x000 -> two ready pulses 7 cycles apart; ram_ad wraps correctly at 0x7FF; no extra RAM accesses.
- Reset in READ cycle 3 -> ready never asserts, rdata=0, ram_ce=0 next cycle; a subsequent read completes normally.
- With BOOTRAM_BRIDGE_WP_EN, wp=1, write 32'hFFFFFFFF to addr 0 -> ready in cycle 1, ram_wre never high, RAM[0..3] unchanged.

Source files
------------

// File: rtl/bootram_bridge_pkg.sv
// Shared types and constants for the boot RAM bus bridge.
//   state_e : bridge FSM states
//   LANES   : byte lanes per 32-bit bus word
//   LANE_W  : bits needed to index a lane
//   BYTE_W  : bits per RAM byte
package bootram_bridge_pkg;

  localparam int unsigned LANES  = 4;
  localparam int unsigned LANE_W = 2;
  localparam int unsigned BYTE_W = 8;

  typedef enum logic [2:0] {
    StIdle,
    StRead,
    StDrain,
    StWrite,
    StResp
  } state_e;

endpackage

// File: rtl/bootram_lane_next.sv
// Lowest-set-lane priority encoder for the byte-enable mask.
// Ports:
//   mask  in  LANES   byte-lane mask
//   lane  out LANE_W  index of the lowest set bit (0 when mask is empty)
//   empty out 1       mask has no bits set
module bootram_lane_next
  import bootram_bridge_pkg::*;
(
  input  logic [LANES-1:0]  mask,
  output logic [LANE_W-1:0] lane,
  output logic              empty
);

  always_comb begin
    lane = '0;
    // Walk downwards so the lowest set bit is the last one written.
    for (int i = LANES - 1; i >= 0; i--) begin
      if (mask[i]) begin
        lane = LANE_W'(i);
      end
    end
    empty = (mask == '0);
  end

endmodule

// File: rtl/bootram_bus_bridge.sv
// Bridge from 32-bit CPU memory requests to the byte-wide 2Kx8 boot RAM port.
// Reads issue four sequential byte reads and assemble them little-endian; writes
// issue one RAM write per enabled byte lane, skipping disabled lanes.
// Optional feature: define BOOTRAM_BRIDGE_WP_EN to add the wp input; when wp=1
// in IDLE a write request completes immediately without touching the RAM.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   valid/ready         request handshake; ready is a one-cycle completion strobe
//   addr, wdata, wstrb  request (held by the master until ready); wstrb=0 is a read
//   rdata               assembled read data, held until the next read completes
//   ram_ce/oce/wre      RAM enables
//   ram_reset           RAM output reset (follows reset)
//   ram_ad/din/dout     RAM byte address, write byte, read byte
//   wp                  write protect (only with BOOTRAM_BRIDGE_WP_EN)
module bootram_bus_bridge #(
  parameter int unsigned ADDR_W = 11,
  parameter int unsigned LANES  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid,
  output logic              ready,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  input  logic [LANES-1:0]  wstrb,
  output logic [31:0]       rdata,
  output logic              ram_ce,
  output logic              ram_oce,
  output logic              ram_wre,
  output logic              ram_reset,
  output logic [ADDR_W-1:0] ram_ad,
  output logic [7:0]        ram_din,
`ifdef BOOTRAM_BRIDGE_WP_EN
  input  logic              wp,
`endif
  input  logic [7:0]        ram_dout
);

  import bootram_bridge_pkg::*;

  state_e             state_q;
  logic [LANE_W-1:0]  lane_q;
  logic [LANES-1:0]   mask_q;
  logic [LANES-1:0]   lane_bit;
  logic [LANES-1:0]   mask_rest;
  logic [LANE_W-1:0]  first_lane;
  logic [LANE_W-1:0]  next_lane;
  logic [LANE_W-1:0]  lane_prev;
  logic               first_empty;
  logic               rest_empty;
  logic               wp_active;
  logic [1:0]         unused_addr;

  // Word-aligned requests: the low address bits are replaced by the lane index.
  assign unused_addr = addr[1:0];

`ifdef BOOTRAM_BRIDGE_WP_EN
  assign wp_active = wp;
`else
  assign wp_active = 1'b0;
`endif

  assign ram_oce   = ram_ce;
  assign ram_reset = reset;
  assign ram_ad    = {addr[ADDR_W-1:LANE_W], lane_q};
  assign ram_din   = wdata[{lane_q, 3'b000} +: BYTE_W];

  always_comb begin
    lane_bit         = '0;
    lane_bit[lane_q] = 1'b1;
    mask_rest        = mask_q & ~lane_bit;
    lane_prev        = lane_q - LANE_W'(1);
  end

  bootram_lane_next u_first (
    .mask  (wstrb),
    .lane  (first_lane),
    .empty (first_empty)
  );

  bootram_lane_next u_next (
    .mask  (mask_rest),
    .lane  (next_lane),
    .empty (rest_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      ready   <= 1'b0;
      rdata   <= '0;
      ram_ce  <= 1'b0;
      ram_wre <= 1'b0;
      lane_q  <= '0;
      mask_q  <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (valid) begin
            if (first_empty) begin
              state_q <= StRead;
              lane_q  <= '0;
              ram_ce  <= 1'b1;
            end else if (wp_active) begin
              state_q <= StResp;
              ready   <= 1'b1;
            end else begin
              state_q <= StWrite;
              mask_q  <= wstrb;
              lane_q  <= first_lane;
              ram_ce  <= 1'b1;
              ram_wre <= 1'b1;
            end
          end
        end
        StRead: begin
          // The byte addressed last cycle is on ram_dout now.
          if (lane_q != '0) begin
            rdata[{lane_prev, 3'b000} +: BYTE_W] <= ram_dout;
          end
          if (lane_q == LANE_W'(LANES - 1)) begin
            state_q <= StDrain;
            ram_ce  <= 1'b0;
          end else begin
            lane_q <= lane_q + LANE_W'(1);
          end
        end
        StDrain: begin
          rdata[31:24] <= ram_dout;
          state_q      <= StResp;
          ready        <= 1'b1;
        end
        StWrite: begin
          mask_q <= mask_rest;
          if (rest_empty) begin
            state_q <= StResp;
            ram_ce  <= 1'b0;
            ram_wre <= 1'b0;
            ready   <= 1'b1;
          end else begin
            lane_q <= next_lane;
          end
        end
        StResp: begin
          ready   <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bootram_bus_bridge.sv
// Self-checking bench for bootram_bus_bridge with a behavioural 2Kx8 RAM model.
module tb_bootram_bus_bridge;

  logic        clk;
  logic        reset;
  logic        valid;
  logic        ready;
  logic [10:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic [31:0] rdata;
  logic        ram_ce;
  logic        ram_oce;
  logic        ram_wre;
  logic        ram_reset;
  logic [10:0] ram_ad;
  logic [7:0]  ram_din;
  logic [7:0]  ram_dout;
`ifdef BOOTRAM_BRIDGE_WP_EN
  logic        wp;
`endif

  bootram_bus_bridge #(
    .ADDR_W (11),
    .LANES  (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .valid     (valid),
    .ready     (ready),
    .addr      (addr),
    .wdata     (wdata),
    .wstrb     (wstrb),
    .rdata     (rdata),
    .ram_ce    (ram_ce),
    .ram_oce   (ram_oce),
    .ram_wre   (ram_wre),
    .ram_reset (ram_reset),
    .ram_ad    (ram_ad),
    .ram_din   (ram_din),
`ifdef BOOTRAM_BRIDGE_WP_EN
    .wp        (wp),
`endif
    .ram_dout  (ram_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bypass-read RAM model plus an access monitor.
  logic [7:0]  mem [2048];
  logic [10:0] ad_log [512];
  int          ce_cnt = 0;
  int          wre_cnt = 0;
  int          ad_n = 0;
  int          oce_bad = 0;

  always @(posedge clk) begin
    if (ram_ce) begin
      if (ram_wre) mem[ram_ad] <= ram_din;
      ram_dout <= ram_wre ? ram_din : mem[ram_ad];
      ce_cnt = ce_cnt + 1;
      if (ram_wre) wre_cnt = wre_cnt + 1;
      if (ad_n < 512) ad_log[ad_n] = ram_ad;
      ad_n = ad_n + 1;
    end
    if (ram_oce !== ram_ce) oce_bad = oce_bad + 1;
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [10:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          cyc;
    int          ce;
    int          wre;
    logic [31:0] rdata;
  } vec_t;

  // One request: cycle 0 is the cycle valid is first presented.
  task automatic run_txn(input string nm, input logic [10:0] a, input logic [31:0] wd,
                         input logic [3:0] ws, input int exp_cyc, input int exp_ce,
                         input int exp_wre, input logic [31:0] exp_rd);
    int          cyc;
    int          ce0;
    int          wre0;
    int          k;
    logic [31:0] rd_at;
    logic [3:0]  m;
    logic [1:0]  ln;
    logic [10:0] exp_ad;
    ce0   = ce_cnt;
    wre0  = wre_cnt;
    k     = ad_n;
    addr  = a;
    wdata = wd;
    wstrb = ws;
    valid = 1'b1;
    cyc   = 0;
    while (cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
      if (ready) break;
    end
    if (!ready) cyc = 99;
    rd_at = rdata;
    valid = 1'b0;
    @(posedge clk); #1;
    chk({nm, " ready_cycle"}, cyc, exp_cyc);
    chk({nm, " ready_one_cycle"}, {31'd0, ready}, 32'd0);
    chk({nm, " rdata"}, rd_at, exp_rd);
    chk({nm, " ce_count"}, ce_cnt - ce0, exp_ce);
    chk({nm, " wre_count"}, wre_cnt - wre0, exp_wre);
    if (exp_ce > 0) begin
      m = (ws == 4'd0) ? 4'hF : ws;
      for (int l = 0; l < 4; l++) begin
        if (m[l]) begin
          ln     = 2'(l);
          exp_ad = {a[10:2], ln};
          if (k < ad_n && k < 512) chk({nm, " ram_ad"}, {21'd0, ad_log[k]}, {21'd0, exp_ad});
          k++;
        end
      end
    end
  endtask

  vec_t vecs [11];

  initial begin
    int cyc;
    int ce0;
    int k;
    int rdy_seen;
    int t1;
    int t2;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [10:0] exp_b2b [8];

    // Preload through the bridge, then exercise reads and partial writes.
    vecs[0]  = '{11'h000, 32'h1313136F, 4'hF, 5, 4, 4, 32'h0};
    vecs[1]  = '{11'h020, 32'hA3A2A1A0, 4'hF, 5, 4, 4, 32'h0};
    vecs[2]  = '{11'h030, 32'h00030201, 4'hF, 5, 4, 4, 32'h0};
    vecs[3]  = '{11'h7FC, 32'h40302010, 4'hF, 5, 4, 4, 32'h0};
    vecs[4]  = '{11'h000, 32'h0,        4'h0, 6, 4, 0, 32'h1313136F};
    vecs[5]  = '{11'h010, 32'hDEADBEEF, 4'hF, 5, 4, 4, 32'h1313136F};
    vecs[6]  = '{11'h010, 32'h0,        4'h0, 6, 4, 0, 32'hDEADBEEF};
    vecs[7]  = '{11'h020, 32'h11223344, 4'h5, 3, 2, 2, 32'hDEADBEEF};
    vecs[8]  = '{11'h020, 32'h0,        4'h0, 6, 4, 0, 32'hA322A144};
    vecs[9]  = '{11'h031, 32'h55000000, 4'h8, 2, 1, 1, 32'hA322A144};
    vecs[10] = '{11'h033, 32'h0,        4'h0, 6, 4, 0, 32'h55030201};

    reset = 1'b1;
    valid = 1'b0;
    addr  = '0;
    wdata = '0;
    wstrb = '0;
`ifdef BOOTRAM_BRIDGE_WP_EN
    wp = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    chk("reset ready", {31'd0, ready}, 32'd0);
    chk("reset rdata", rdata, 32'd0);
    chk("reset ram_ce", {31'd0, ram_ce}, 32'd0);
    chk("reset ram_wre", {31'd0, ram_wre}, 32'd0);
    chk("reset ram_reset", {31'd0, ram_reset}, 32'd1);
    reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 11; i++) begin
      run_txn($sformatf("vec%0d", i), vecs[i].addr, vecs[i].wdata, vecs[i].wstrb,
              vecs[i].cyc, vecs[i].ce, vecs[i].wre, vecs[i].rdata);
    end

    chk("mem 0x10", {24'd0, mem[11'h010]}, 32'hEF);
    chk("mem 0x13", {24'd0, mem[11'h013]}, 32'hDE);
    chk("mem 0x20", {24'd0, mem[11'h020]}, 32'h44);
    chk("mem 0x21 untouched", {24'd0, mem[11'h021]}, 32'hA1);
    chk("mem 0x22", {24'd0, mem[11'h022]}, 32'h22);
    chk("mem 0x23 untouched", {24'd0, mem[11'h023]}, 32'hA3);

    // Back-to-back reads 0x7FC then 0x000 with valid held through RESP.
    exp_b2b = '{11'h7FC, 11'h7FD, 11'h7FE, 11'h7FF, 11'h000, 11'h001, 11'h002, 11'h003};
    ce0   = ce_cnt;
    k     = ad_n;
    t1    = 0;
    t2    = 0;
    rd1   = '0;
    rd2   = '0;
    addr  = 11'h7FC;
    wstrb = 4'h0;
    valid = 1'b1;
    cyc   = 0;
    while (cyc < 40 && t2 == 0) begin
      @(posedge clk); #1;
      cyc++;
      if (ready) begin
        if (t1 == 0) begin
          t1   = cyc;
          rd1  = rdata;
          addr = 11'h000;
        end else begin
          t2    = cyc;
          rd2   = rdata;
          valid = 1'b0;
        end
      end
    end
    valid = 1'b0;
    @(posedge clk); #1;
    chk("b2b first ready", t1, 6);
    chk("b2b second ready", t2, 13);
    chk("b2b rdata 1", rd1, 32'h40302010);
    chk("b2b rdata 2", rd2, 32'h1313136F);
    chk("b2b ce_count", ce_cnt - ce0, 8);
    for (int i = 0; i < 8; i++) begin
      if (k + i < ad_n) chk("b2b ram_ad", {21'd0, ad_log[k + i]}, {21'd0, exp_b2b[i]});
    end

`ifdef BOOTRAM_BRIDGE_WP_EN
    wp = 1'b1;
    run_txn("wp write", 11'h000, 32'hFFFFFFFF, 4'hF, 1, 0, 0, 32'h1313136F);
    wp = 1'b0;
    run_txn("wp readback", 11'h000, 32'h0, 4'h0, 6, 4, 0, 32'h1313136F);
`endif

    // Reset during READ cycle 3 aborts the request without a ready.
    addr  = 11'h010;
    wstrb = 4'h0;
    valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    valid = 1'b0;
    @(posedge clk); #1;
    chk("abort ready", {31'd0, ready}, 32'd0);
    chk("abort rdata", rdata, 32'd0);
    chk("abort ram_ce", {31'd0, ram_ce}, 32'd0);
    reset    = 1'b0;
    rdy_seen = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (ready) rdy_seen++;
    end
    chk("abort no ready", rdy_seen, 0);
    run_txn("after abort", 11'h010, 32'h0, 4'h0, 6, 4, 0, 32'hDEADBEEF);

    chk("ram_oce tracks ram_ce", oce_bad, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
